// File: rtl/zueirai_int_ctrl.sv
// Vectored interrupt controller: synchronised edge capture, pending latch, fixed-priority
// req/ack/eoi handshake. Define ZUEIRAI_INT_NEST_EN for preemptive nesting with an in-service stack.
module zueirai_int_ctrl #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_W       = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      int_io,
  input  logic [2*N_CH-1:0]    int_mode,
  input  logic [N_CH-1:0]      int_en,
  input  logic [N_CH-1:0]      int_clr,
  input  logic                 int_ack,
  input  logic                 int_eoi,
  output logic                 int_flag,
  output logic [VEC_W-1:0]     int_vec,
  output logic [N_CH-1:0]      int_pending,
  output logic                 int_busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [N_CH-1:0]  sync_p [SYNC_STAGES];
  logic [N_CH-1:0]  line_s;
  logic [N_CH-1:0]  prev_p1;
  logic [N_CH-1:0]  rise, fall, hit;
  logic [N_CH-1:0]  pend_q, pend_set, ack_clr, req;
  logic [VEC_W-1:0] enc;
  logic             withdraw;
  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;

  function automatic logic [VEC_W-1:0] enc_lowest(input logic [N_CH-1:0] r);
    enc_lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (r[i]) enc_lowest = VEC_W'(i);
  endfunction

  // Stage p0: synchroniser chain, p1: previous sample for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_p1 <= '0;
    end else begin
      sync_p[0] <= int_io;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p1 <= line_s;
    end
  end

  assign line_s = sync_p[SYNC_STAGES-1];
  assign rise   = line_s & ~prev_p1;
  assign fall   = ~line_s & prev_p1;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (int_mode[2*i +: 2])
        2'b01:   hit[i] = rise[i];
        2'b10:   hit[i] = fall[i];
        2'b11:   hit[i] = rise[i] | fall[i];
        default: hit[i] = 1'b0;
      endcase
    end
  end

  // Stage p2: pending latch; a fresh edge beats any clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= (pend_q & ~int_clr & ~ack_clr) | hit;
  end

  assign pend_set = (pend_q & ~int_clr) | hit;
  assign req      = pend_q & int_en;
  assign enc      = enc_lowest(req);
  assign withdraw = ~int_en[vec_q] | ~pend_set[vec_q];

`ifdef ZUEIRAI_INT_NEST_EN
  localparam int SP_W = $clog2(N_CH + 1);
  logic [VEC_W-1:0] stk_q [N_CH];
  logic [SP_W-1:0]  sp_q;
  logic             push, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sp_q <= '0;
    else if (push) sp_q <= sp_q + 1'b1;
    else if (pop)  sp_q <= sp_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) stk_q[VEC_W'(sp_q)] <= vec_q;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ack_clr = '0;
`ifdef ZUEIRAI_INT_NEST_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = REQ;
          vec_d   = enc;
        end
      end
      REQ: begin
        // Withdrawal takes precedence over an ack arriving in the same cycle
        if (withdraw) begin
          state_d = IDLE;
`ifdef ZUEIRAI_INT_NEST_EN
          if (sp_q != '0) begin
            state_d = SERVICE;
            vec_d   = stk_q[VEC_W'(sp_q - 1'b1)];
          end
`endif
        end else if (int_ack) begin
          state_d          = SERVICE;
          ack_clr[vec_q]   = 1'b1;
`ifdef ZUEIRAI_INT_NEST_EN
          push             = 1'b1;
`endif
        end
      end
      SERVICE: begin
        if (int_eoi) begin
          state_d = IDLE;
`ifdef ZUEIRAI_INT_NEST_EN
          pop = 1'b1;
          if (sp_q > SP_W'(1)) begin
            state_d = SERVICE;
            vec_d   = stk_q[VEC_W'(sp_q - SP_W'(2))];
          end
`endif
        end
`ifdef ZUEIRAI_INT_NEST_EN
        else if ((|req) && (enc < vec_q)) begin
          state_d = REQ;
          vec_d   = enc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_flag    = (state_q == REQ);
  assign int_vec     = vec_q;
  assign int_pending = pend_q;
`ifdef ZUEIRAI_INT_NEST_EN
  assign int_busy    = (state_q == SERVICE) || ((state_q == REQ) && (sp_q != '0));
`else
  assign int_busy    = (state_q == SERVICE);
`endif

endmodule

// File: tb/tb_zueirai_int_ctrl.sv
// Scoreboard bench for zueirai_int_ctrl: a behavioural model queues the expected outputs
// after every clock, an independent monitor pops and compares them.
module tb_zueirai_int_ctrl;
  localparam int N = 8;
  localparam int S = 2;
`ifdef ZUEIRAI_INT_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   io, en, clr, pending;
  logic [2*N-1:0] mode;
  logic           ack, eoi, flag, busy;
  logic [2:0]     vec;

  zueirai_int_ctrl #(.N_CH(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .int_io(io), .int_mode(mode), .int_en(en), .int_clr(clr),
    .int_ack(ack), .int_eoi(eoi), .int_flag(flag), .int_vec(vec),
    .int_pending(pending), .int_busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       flag;
    logic [2:0] vec;
    logic       busy;
    logic [N-1:0] pend;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: delay line for the synchroniser, a requesting bit and a list of in-service vectors
  logic [N-1:0] m_dl [S];
  logic [N-1:0] m_prev, m_pend;
  bit           m_reqing;
  int           m_vec;
  int           m_stk[$];

  task automatic model_reset();
    for (int j = 0; j < S; j++) m_dl[j] = '0;
    m_prev = '0; m_pend = '0; m_reqing = 0; m_vec = 0;
    m_stk.delete();
  endtask

  task automatic model_eval();
    logic [N-1:0] s, rise, fall, hit, req, after_clr, ackclr;
    logic [1:0]   md;
    int           low;
    exp_t         e;
    s    = m_dl[S-1];
    rise = s & ~m_prev;
    fall = ~s & m_prev;
    for (int i = 0; i < N; i++) begin
      md = mode[2*i +: 2];
      hit[i] = (md == 2'd1 && rise[i]) || (md == 2'd2 && fall[i]) || (md == 2'd3 && (rise[i] || fall[i]));
    end
    req = m_pend & en;
    low = -1;
    for (int i = N - 1; i >= 0; i--) if (req[i]) low = i;
    after_clr = (m_pend & ~clr) | hit;
    ackclr = '0;
    if (m_reqing) begin
      if (!en[m_vec] || !after_clr[m_vec]) begin
        m_reqing = 0;
        if (m_stk.size() > 0) m_vec = m_stk[$];
      end else if (ack) begin
        m_stk.push_back(m_vec);
        ackclr[m_vec] = 1'b1;
        m_reqing = 0;
      end
    end else if (m_stk.size() > 0) begin
      if (eoi) begin
        void'(m_stk.pop_back());
        if (m_stk.size() > 0) m_vec = m_stk[$];
      end else if (NEST && low >= 0 && low < m_vec) begin
        m_reqing = 1; m_vec = low;
      end
    end else if (low >= 0) begin
      m_reqing = 1; m_vec = low;
    end
    m_pend = (m_pend & ~clr & ~ackclr) | hit;
    m_prev = s;
    for (int j = S - 1; j > 0; j--) m_dl[j] = m_dl[j-1];
    m_dl[0] = io;
    e.flag = m_reqing; e.vec = 3'(m_vec); e.busy = (m_stk.size() > 0); e.pend = m_pend;
    sb_q.push_back(e);
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #3;
    ack = 1'b0; eoi = 1'b0; clr = '0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_flag", 32'(flag), 32'(e.flag));
      chk("sb_vec", 32'(vec), 32'(e.vec));
      chk("sb_busy", 32'(busy), 32'(e.busy));
      chk("sb_pending", 32'(pending), 32'(e.pend));
    end
  end

  initial begin
    io = '0; en = '1; clr = '0; mode = '0; ack = 1'b0; eoi = 1'b0;
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    #20;
    chk("rst_flag", 32'(flag), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vec", 32'(vec), 0);
    chk("rst_pending", 32'(pending), 0);
    @(posedge clk); #3;
    rst = 1'b1;

    // Single rising edge on ch3 through the full handshake
    set_mode(3, 2'b01);
    steps(2);
    io[3] = 1'b1;
    steps(3);
    chk("ch3_pend_k2", 32'(pending), 32'h08);
    chk("ch3_flag_k2", 32'(flag), 0);
    step();
    chk("ch3_flag_k3", 32'(flag), 1);
    chk("ch3_vec_k3", 32'(vec), 3);
    ack = 1'b1; step();
    chk("ch3_ack_pend", 32'(pending), 0);
    chk("ch3_ack_busy", 32'(busy), 1);
    eoi = 1'b1; step();
    chk("ch3_eoi_busy", 32'(busy), 0);
    io[3] = 1'b0; steps(3);

    // Simultaneous ch5/ch1: lowest index wins, ch5 served afterwards
    set_mode(5, 2'b01); set_mode(1, 2'b01);
    io[5] = 1'b1; io[1] = 1'b1;
    steps(4);
    chk("prio_vec_first", 32'(vec), 1);
    ack = 1'b1; step();
    eoi = 1'b1; step();
    step();
    chk("prio_vec_second", 32'(vec), 5);
    chk("prio_flag_second", 32'(flag), 1);
    ack = 1'b1; step();
    eoi = 1'b1; step();
    io[5] = 1'b0; io[1] = 1'b0; steps(3);

    // Falling edge on ch2, mode-off ch6 never latches
    set_mode(2, 2'b10);
    io[2] = 1'b1; steps(3);
    chk("ch2_rise_ignored", 32'(pending[2]), 0);
    io[2] = 1'b0; steps(3);
    chk("ch2_fall_pend", 32'(pending[2]), 1);
    io[6] = 1'b1; step(); io[6] = 1'b0; step(); io[6] = 1'b1; steps(4);
    chk("ch6_off", 32'(pending[6]), 0);
    ack = 1'b1; step();
    eoi = 1'b1; step();

    // Masked channel latches but does not request
    en[4] = 1'b0; set_mode(4, 2'b01); io[4] = 1'b1;
    steps(5);
    chk("ch4_masked_flag", 32'(flag), 0);
    chk("ch4_masked_pend", 32'(pending), 32'h10);
    en[4] = 1'b1; step();
    chk("ch4_unmask_flag", 32'(flag), 1);
    ack = 1'b1; step();
    eoi = 1'b1; step();

    // Set beats clear; clearing the requested bit withdraws the request
    set_mode(0, 2'b01); io[0] = 1'b1;
    steps(2);
    clr = 8'h01; step();
    chk("set_wins", 32'(pending[0]), 1);
    step();
    chk("ch0_flag", 32'(flag), 1);
    chk("ch0_vec", 32'(vec), 0);
    clr = 8'h01; step();
    chk("withdraw_flag", 32'(flag), 0);
    steps(2);

`ifdef ZUEIRAI_INT_NEST_EN
    set_mode(6, 2'b01); set_mode(1, 2'b01);
    io[6] = 1'b1; steps(4);
    ack = 1'b1; step();
    io[1] = 1'b1; steps(4);
    chk("nest_flag", 32'(flag), 1);
    chk("nest_vec", 32'(vec), 1);
    chk("nest_busy", 32'(busy), 1);
    ack = 1'b1; step();
    eoi = 1'b1; step();
    chk("nest_pop_vec", 32'(vec), 6);
    chk("nest_pop_busy", 32'(busy), 1);
    eoi = 1'b1; step();
    chk("nest_done_busy", 32'(busy), 0);
    io[6] = 1'b0; io[1] = 1'b0; steps(3);
`endif

    // Randomised traffic
    mode = 16'($urandom);
    for (int c = 0; c < 1500; c++) begin
      io = io ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 31) == 0) mode = 16'($urandom);
      if ($urandom_range(0, 15) == 0) en = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 15) == 0) clr = 8'(1 << $urandom_range(0, 7));
      ack = ($urandom_range(0, 2) == 0);
      eoi = ($urandom_range(0, 3) == 0);
      step();
    end

    // Drive into SERVICE, then assert reset between clock edges
    en = '1; set_mode(0, 2'b11);
    for (int c = 0; c < 200; c++) begin
      io[0] = ~io[0];
      if (m_reqing) ack = 1'b1;
      step();
      if (m_stk.size() > 0 && !m_reqing) break;
    end
    chk("reach_service", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_flag", 32'(flag), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_pending", 32'(pending), 0);
    model_reset();
    sb_q.delete();
    #2 rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ack = ($urandom_range(0, 1) == 0);
      eoi = ($urandom_range(0, 2) == 0);
      step();
    end

    #20;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zueirai_int_ctrl.md
Name: zueirai_int_ctrl

Overview:
- Parametrised successor to the ZueiraI interrupt block: N_CH external interrupt lines.
- Each line passes through a synchroniser, then edge detection configured per channel.
- Detected edges latch into a pending register. A fixed-priority encoder issues one vectored request to the core.
- The request follows an explicit req/ack/eoi handshake. Flag clearing is synchronous; there are no edge-triggered always blocks on data lines.

Parameters:
- N_CH, 8: number of interrupt channels (2..32).
- SYNC_STAGES, 2: synchroniser flops per input (>=2).
- VEC_W, $clog2(N_CH): width of the vector output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous active-low.
- int_io  in  N_CH  raw interrupt lines, asynchronous to clk.
- int_mode  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both edges.
- int_en  in  N_CH  per-channel request enable (mask).
- int_clr  in  N_CH  synchronous clear of pending bits, one-cycle pulse per bit.
- int_ack  in  1  core accepts the current request (pulse).
- int_eoi  in  1  core finished the service routine (RETI pulse).
- int_flag  out  1  interrupt request to core.
- int_vec  out  VEC_W  index of the requested/in-service channel.
- int_pending  out  N_CH  pending register, readable as a status register.
- int_busy  out  1  high while in SERVICE.

Behaviour:
- Reset (rst=0, async): synchroniser flops, previous-sample register, pending, state=IDLE, int_flag=0, int_vec=0, int_busy=0. The previous-sample register resets to 0, so a line held high through reset produces a rising edge after release if mode=01/11. This is intended.
- Synchroniser: int_io passes through SYNC_STAGES flops to give s[i]; prev[i] <= s[i] every cycle.
- Edge detect (combinational):
  - rise[i] = s & ~prev; fall[i] = ~s & prev.
  - hit[i] = (mode==01 & rise) | (mode==10 & fall) | (mode==11 & (rise|fall)).
  - mode 00 never sets pending.
- Pending update per bit, next cycle: pending <= (pending & ~int_clr & ~ack_clr) | hit.
  - Set wins over any clear in the same cycle.
  - ack_clr is the one-hot of the vector being acknowledged.
  - int_en does not gate capture, only the request.
- Latency: a line transition sampled by the first sync flop at edge k sets pending at edge k+SYNC_STAGES and raises int_flag at edge k+SYNC_STAGES+1.
- Request vector: req = pending & int_en. The priority encoder selects the lowest index set bit (channel 0 is highest priority).
- FSM:
  - IDLE: int_flag=0, int_busy=0. If req!=0, go to REQ and register int_vec=encoded index, int_flag=1.
  - REQ: int_flag=1 and int_vec held stable, even if higher-priority pending arrives. On int_ack, go to SERVICE: clear pending[int_vec], int_flag=0, int_busy=1. If int_en[int_vec] or pending[int_vec] drops (via int_clr) before ack, return to IDLE with int_flag=0. The request is withdrawn; that cycle's ack is ignored.
  - SERVICE: int_busy=1, int_vec held. Ignores int_ack. New edges keep latching into pending. On int_eoi, go to IDLE; re-arbitration happens the following cycle.
  - int_eoi outside SERVICE is ignored.
- Simultaneous int_ack and int_eoi in REQ: ack is processed, eoi is ignored.
- N_CH not a power of two: vectors >= N_CH are never produced.

Optional Feature:
- Macro: ZUEIRAI_INT_NEST_EN.
- When defined:
  - SERVICE also arbitrates. A req index strictly lower than the current in-service index moves to REQ with the new vector (int_busy stays 1).
  - On ack, the current vector is pushed onto an in-service stack of depth N_CH.
  - int_eoi pops the stack. When the stack is empty it returns to IDLE; otherwise it stays in SERVICE with int_vec = popped vector.
  - Equal or lower priority never preempts.
- When undefined: no nesting, exactly the FSM above, and no stack logic is instantiated.

Test Plan:
- Reset with int_io=8'h00, then mode ch3=01, en=8'hFF, pulse int_io[3] high -> pending=8'h08 at k+2, int_flag=1 and int_vec=3 at k+3; ack -> pending=0, int_busy=1; eoi -> int_busy=0.
- Rising edges on ch5 and ch1 in the same cycle, both enabled -> int_vec=1 first; after ack+eoi -> int_vec=5.
- ch2 mode=10, int_io[2] 1->0 -> pending[2]=1; mode=00 toggling ch6 -> pending[6] never set.
- ch4 pending with int_en[4]=0 -> int_flag stays 0 and int_pending=8'h10; set int_en[4]=1 -> int_flag at next+1 cycle.
- Same cycle: new edge on ch0 and int_clr[0]=1 -> pending[0]=1 (set wins). In REQ, int_clr of the requested bit -> int_flag drops, returns to IDLE.
- Assert rst low mid-SERVICE, asynchronously between edges -> int_flag, int_busy, int_pending all 0 immediately. With ZUEIRAI_INT_NEST_EN, servicing ch6 then a ch1 edge -> int_flag=1, int_vec=1; after ack and eoi -> int_vec=6, int_busy=1.
